// File: rtl/exc_ctrl_if.sv
// Bundle of MEM-stage, CP0 and PC-control signals between the core and the
// exception sequencer.
interface exc_ctrl_if;
  logic        mem_valid_i;
  logic [31:0] mem_pc_i;
  logic [3:0]  mem_exc_i;
  logic [5:0]  int_i;
  logic [31:0] cp0_count_i;
  logic [31:0] cp0_compare_i;
  logic        cp0_compare_we_i;
  logic [31:0] cp0_epc_i;
  logic [31:0] excepttype_o;
  logic [31:0] current_pc_o;
  logic        flush_o;
  logic        stall_o;
  logic        pc_we_o;
  logic [31:0] new_pc_o;
  logic        exl_o;
  logic        timer_int_o;

  // Core/pipeline side: supplies MEM and CP0 state, consumes control.
  modport master (
    output mem_valid_i, mem_pc_i, mem_exc_i, int_i,
           cp0_count_i, cp0_compare_i, cp0_compare_we_i, cp0_epc_i,
    input  excepttype_o, current_pc_o, flush_o, stall_o,
           pc_we_o, new_pc_o, exl_o, timer_int_o
  );

  // Sequencer side.
  modport slave (
    input  mem_valid_i, mem_pc_i, mem_exc_i, int_i,
           cp0_count_i, cp0_compare_i, cp0_compare_we_i, cp0_epc_i,
    output excepttype_o, current_pc_o, flush_o, stall_o,
           pc_we_o, new_pc_o, exl_o, timer_int_o
  );
endinterface

// File: rtl/exc_ctrl.sv
// Exception/interrupt sequencer: prioritises MEM-stage exceptions against
// interrupts, notifies CP0, flushes the pipeline and redirects fetch.
module exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR   = 32'h0000_0040,
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter logic [5:0]  INT_MASK     = 6'b111111
) (
  input logic       clk,
  input logic       rst,
  exc_ctrl_if.slave bus
);

  localparam int unsigned CNT_W  = 4;
  localparam int unsigned CODE_W = 32;
  localparam bit          DIRECT_REDIRECT = (FLUSH_CYCLES <= 1);

  localparam logic [CODE_W-1:0] CODE_INT  = CODE_W'(32'h1);
  localparam logic [CODE_W-1:0] CODE_RI   = CODE_W'(32'ha);
  localparam logic [CODE_W-1:0] CODE_OV   = CODE_W'(32'hc);
  localparam logic [CODE_W-1:0] CODE_SYS  = CODE_W'(32'h8);
  localparam logic [CODE_W-1:0] CODE_ERET = CODE_W'(32'he);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    NOTIFY   = 2'd1,
    FLUSH    = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               is_eret_q, is_eret_d;
  logic [CODE_W-1:0]  excepttype_q, excepttype_d;
  logic [31:0]        current_pc_q, current_pc_d;
  logic               flush_q, flush_d;
  logic               stall_q, stall_d;
  logic               pc_we_q, pc_we_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic               exl_q, exl_d;
  logic               timer_q, timer_d;

  logic               timer_match;
  logic [5:0]         int_vec;
  logic               int_pend;
  logic               trigger;
  logic [CODE_W-1:0]  sel_code;
  logic               sel_eret;
  logic [31:0]        redirect_pc;

  // Timer latch: a Compare write clears it and beats a same-cycle match.
  always_comb begin
    timer_match = (bus.cp0_compare_i != 32'd0) &&
                  (bus.cp0_count_i == bus.cp0_compare_i);
    timer_d = timer_q;
    if (bus.cp0_compare_we_i) begin
      timer_d = 1'b0;
    end else if (timer_match) begin
      timer_d = 1'b1;
    end
  end

  // Timer shares hardware line 5; all interrupts are masked at exception level.
  always_comb begin
    int_vec  = {bus.int_i[5] | timer_q, bus.int_i[4:0]} & INT_MASK;
    int_pend = (|int_vec) && !exl_q;
    trigger  = bus.mem_valid_i && (int_pend || (|bus.mem_exc_i));
  end

  // Priority: interrupt > reserved-instr > overflow > syscall > eret.
  always_comb begin
    sel_code = CODE_ERET;
    sel_eret = 1'b0;
    if (int_pend) begin
      sel_code = CODE_INT;
    end else if (bus.mem_exc_i[1]) begin
      sel_code = CODE_RI;
    end else if (bus.mem_exc_i[2]) begin
      sel_code = CODE_OV;
    end else if (bus.mem_exc_i[0]) begin
      sel_code = CODE_SYS;
    end else begin
      sel_code = CODE_ERET;
      sel_eret = 1'b1;
    end
  end

  assign redirect_pc = is_eret_q ? bus.cp0_epc_i : EXC_VECTOR;

  // Next-state and registered-output decode; outputs reflect the state entered.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    is_eret_d    = is_eret_q;
    excepttype_d = '0;
    current_pc_d = '0;
    flush_d      = 1'b0;
    stall_d      = 1'b0;
    pc_we_d      = 1'b0;
    new_pc_d     = new_pc_q;
    exl_d        = exl_q;

    unique case (state_q)
      IDLE: begin
        if (trigger) begin
          state_d      = NOTIFY;
          is_eret_d    = sel_eret;
          excepttype_d = sel_code;
          current_pc_d = bus.mem_pc_i;
          flush_d      = 1'b1;
          stall_d      = 1'b1;
        end
      end

      NOTIFY: begin
        exl_d = !is_eret_q;
        if (DIRECT_REDIRECT) begin
          state_d  = REDIRECT;
          pc_we_d  = 1'b1;
          stall_d  = 1'b1;
          new_pc_d = redirect_pc;
        end else begin
          state_d = FLUSH;
          cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end

      FLUSH: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          state_d  = REDIRECT;
          pc_we_d  = 1'b1;
          stall_d  = 1'b1;
          new_pc_d = redirect_pc;
        end else begin
          flush_d = 1'b1;
          stall_d = 1'b1;
        end
      end

      REDIRECT: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any sequence in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      is_eret_q    <= 1'b0;
      excepttype_q <= '0;
      current_pc_q <= '0;
      flush_q      <= 1'b0;
      stall_q      <= 1'b0;
      pc_we_q      <= 1'b0;
      new_pc_q     <= '0;
      exl_q        <= 1'b0;
      timer_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      is_eret_q    <= is_eret_d;
      excepttype_q <= excepttype_d;
      current_pc_q <= current_pc_d;
      flush_q      <= flush_d;
      stall_q      <= stall_d;
      pc_we_q      <= pc_we_d;
      new_pc_q     <= new_pc_d;
      exl_q        <= exl_d;
      timer_q      <= timer_d;
    end
  end

  assign bus.excepttype_o = excepttype_q;
  assign bus.current_pc_o = current_pc_q;
  assign bus.flush_o      = flush_q;
  assign bus.stall_o      = stall_q;
  assign bus.pc_we_o      = pc_we_q;
  assign bus.new_pc_o     = new_pc_q;
  assign bus.exl_o        = exl_q;
  assign bus.timer_int_o  = timer_q;

endmodule

// File: tb/tb_exc_ctrl.sv
// Directed bench for exc_ctrl with hand-computed expectations.
module tb_exc_ctrl;

  logic clk;
  logic rst;
  int   n_tot;
  int   n_bad;

  exc_ctrl_if bus();

  exc_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_valid_i      = 1'b0;
    bus.mem_pc_i         = 32'h0;
    bus.mem_exc_i        = 4'b0;
    bus.cp0_compare_we_i = 1'b0;
  endtask

  // Full sequence with FLUSH_CYCLES=2: trigger at T, notify T+1, redirect T+3.
  // Noise on the MEM inputs during the sequence must be ignored.
  task automatic run_seq(input string tag, input logic [31:0] pc, input logic [3:0] exc,
                         input logic [5:0] irq, input logic [31:0] code,
                         input logic [31:0] target, input logic exl_after);
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = pc;
    bus.mem_exc_i   = exc;
    bus.int_i       = irq;
    tick();
    check({tag, ".code"},  bus.excepttype_o, code);
    check({tag, ".pc"},    bus.current_pc_o, pc);
    check({tag, ".flush1"}, 32'(bus.flush_o), 32'd1);
    check({tag, ".stall1"}, 32'(bus.stall_o), 32'd1);
    bus.mem_pc_i  = 32'hdead_0000;
    bus.mem_exc_i = 4'b0100;
    tick();
    check({tag, ".code0"},  bus.excepttype_o, 32'h0);
    check({tag, ".flush2"}, 32'(bus.flush_o), 32'd1);
    check({tag, ".pcwe2"},  32'(bus.pc_we_o), 32'd0);
    check({tag, ".exl"},    32'(bus.exl_o), 32'(exl_after));
    tick();
    check({tag, ".pcwe3"},  32'(bus.pc_we_o), 32'd1);
    check({tag, ".newpc"},  bus.new_pc_o, target);
    check({tag, ".flush3"}, 32'(bus.flush_o), 32'd0);
    check({tag, ".stall3"}, 32'(bus.stall_o), 32'd1);
    tick();
    check({tag, ".pcwe4"},  32'(bus.pc_we_o), 32'd0);
    check({tag, ".stall4"}, 32'(bus.stall_o), 32'd0);
    check({tag, ".code4"},  bus.excepttype_o, 32'h0);
    check({tag, ".hold"},   bus.new_pc_o, target);
    idle_inputs();
  endtask

  initial begin
    n_tot = 0;
    n_bad = 0;
    rst   = 1'b0;
    idle_inputs();
    bus.int_i         = 6'h3f;
    bus.cp0_count_i   = 32'd7;
    bus.cp0_compare_i = 32'd7;
    bus.cp0_epc_i     = 32'h200;

    // Reset held with busy inputs: everything stays 0.
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 4'b1111;
    bus.mem_pc_i    = 32'h1234;
    tick();
    tick();
    check("rst.code",  bus.excepttype_o, 32'h0);
    check("rst.cpc",   bus.current_pc_o, 32'h0);
    check("rst.flush", 32'(bus.flush_o), 32'd0);
    check("rst.stall", 32'(bus.stall_o), 32'd0);
    check("rst.pcwe",  32'(bus.pc_we_o), 32'd0);
    check("rst.newpc", bus.new_pc_o, 32'h0);
    check("rst.exl",   32'(bus.exl_o), 32'd0);
    check("rst.timer", 32'(bus.timer_int_o), 32'd0);
    idle_inputs();
    bus.int_i         = 6'b0;
    bus.cp0_count_i   = 32'd0;
    bus.cp0_compare_i = 32'd100;
    rst = 1'b1;
    tick();

    run_seq("sys", 32'h100, 4'b0001, 6'b0, 32'h8, 32'h40, 1'b1);

    // Masked interrupt at exception level: no trigger.
    bus.int_i       = 6'b100000;
    bus.mem_valid_i = 1'b1;
    bus.mem_pc_i    = 32'h150;
    tick();
    check("mask.code",  bus.excepttype_o, 32'h0);
    check("mask.flush", 32'(bus.flush_o), 32'd0);
    idle_inputs();

    run_seq("eret", 32'h180, 4'b1000, 6'b100000, 32'he, 32'h200, 1'b0);

    // Interrupt now pending but no valid instruction: it waits.
    tick();
    check("wait.code",  bus.excepttype_o, 32'h0);
    check("wait.flush", 32'(bus.flush_o), 32'd0);

    run_seq("irq", 32'h300, 4'b0000, 6'b100000, 32'h1, 32'h40, 1'b1);
    run_seq("ri",  32'h400, 4'b0110, 6'b000000, 32'ha, 32'h40, 1'b1);
    run_seq("eret2", 32'h500, 4'b1000, 6'b000001, 32'he, 32'h200, 1'b0);
    // Back-to-back: accepted the cycle after REDIRECT; interrupt beats RI/OV.
    run_seq("pri", 32'h600, 4'b0110, 6'b000001, 32'h1, 32'h40, 1'b1);
    run_seq("ov",  32'h700, 4'b0100, 6'b000000, 32'hc, 32'h40, 1'b1);
    run_seq("sys_eret", 32'h800, 4'b1001, 6'b000000, 32'h8, 32'h40, 1'b1);

    // Timer latch.
    bus.int_i         = 6'b0;
    bus.cp0_compare_i = 32'd5;
    bus.cp0_count_i   = 32'd4;
    tick();
    check("tmr.pre", 32'(bus.timer_int_o), 32'd0);
    bus.cp0_count_i = 32'd5;
    tick();
    check("tmr.set", 32'(bus.timer_int_o), 32'd1);
    bus.cp0_count_i = 32'd6;
    tick();
    check("tmr.hold", 32'(bus.timer_int_o), 32'd1);
    bus.cp0_compare_we_i = 1'b1;
    tick();
    check("tmr.clr", 32'(bus.timer_int_o), 32'd0);
    bus.cp0_count_i = 32'd5;
    tick();
    check("tmr.clrwins", 32'(bus.timer_int_o), 32'd0);
    bus.cp0_compare_we_i = 1'b0;
    bus.cp0_compare_i    = 32'd0;
    bus.cp0_count_i      = 32'd0;
    tick();
    check("tmr.zero", 32'(bus.timer_int_o), 32'd0);
    bus.cp0_compare_i = 32'd100;

    // Reset in the middle of FLUSH aborts the sequence.
    bus.mem_valid_i = 1'b1;
    bus.mem_exc_i   = 4'b0001;
    bus.mem_pc_i    = 32'h900;
    tick();
    idle_inputs();
    tick();
    check("abort.inflush", 32'(bus.flush_o), 32'd1);
    rst = 1'b0;
    #1;
    check("abort.flush", 32'(bus.flush_o), 32'd0);
    check("abort.exl",   32'(bus.exl_o), 32'd0);
    check("abort.newpc", bus.new_pc_o, 32'h0);
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("abort.pcwe",  32'(bus.pc_we_o), 32'd0);
      check("abort.stall", 32'(bus.stall_o), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
